// File: rtl/commit_trace_sched.sv
// Commit-record FIFO between core retirement and the simulator trace bridge.
// On ebreak it stops intake, drains, waits HALT_WAIT cycles and raises a sticky halt.
module commit_trace_sched #(
    parameter int DEPTH     = 4,
    parameter int HALT_WAIT = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmt_valid_i,
    output logic                         cmt_ready_o,
    input  logic [63:0]                  cmt_pc_i,
    input  logic [31:0]                  cmt_inst_i,
    input  logic                         cmt_ebreak_i,
    input  logic [63:0]                  cmt_a0_i,
    output logic                         tr_valid_o,
    input  logic                         tr_ready_i,
    output logic [63:0]                  tr_pc_o,
    output logic [31:0]                  tr_inst_o,
    output logic [31:0]                  tr_flag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         halt_o,
    output logic [63:0]                  exit_code_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (HALT_WAIT > 1) ? $clog2(HALT_WAIT) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, WAIT, HALT} state_t;

    logic [63:0]       pcMem_q   [DEPTH];
    logic [31:0]       instMem_q [DEPTH];
    logic [DEPTH-1:0]  ebMem_q;
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [CW-1:0]     count_q;
    state_t            state_q, state_d;
    logic [WW-1:0]     waitCnt_q, waitCnt_d;
    logic              halt_q;
    logic [63:0]       exitCode_q;

    logic accept, emit, ebEmit;

    assign accept = cmt_valid_i & cmt_ready_o;
    assign emit   = tr_valid_o & tr_ready_i;
    assign ebEmit = emit & ebMem_q[rdPtr_q];

    // Payload storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pcMem_q[wrPtr_q]   <= cmt_pc_i;
            instMem_q[wrPtr_q] <= cmt_inst_i;
            ebMem_q[wrPtr_q]   <= cmt_ebreak_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
            exitCode_q <= '0;
        end else begin
            if (accept) wrPtr_q <= wrPtr_q + 1'b1;
            if (emit)   rdPtr_q <= rdPtr_q + 1'b1;
            case ({accept, emit})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Halt lags the HALT state by one edge so the wait spans HALT_WAIT full cycles.
            halt_q <= halt_q | (state_q == HALT);
            if (accept && cmt_ebreak_i) exitCode_q <= cmt_a0_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            RUN: begin
                if (accept && cmt_ebreak_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (ebEmit) begin
                    if (HALT_WAIT == 0) begin
                        state_d = HALT;
                    end else begin
                        state_d   = WAIT;
                        waitCnt_d = WW'(HALT_WAIT - 1);
                    end
                end
            end
            WAIT: begin
                if (waitCnt_q == '0) state_d = HALT;
                else                 waitCnt_d = waitCnt_q - 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cmt_ready_o = (state_q == RUN) && (count_q != CW'(DEPTH));
        tr_valid_o  = (count_q != '0);
        tr_pc_o     = pcMem_q[rdPtr_q];
        tr_inst_o   = instMem_q[rdPtr_q];
        tr_flag_o   = {31'd0, ebMem_q[rdPtr_q]};
        count_o     = count_q;
        halt_o      = halt_q;
        exit_code_o = exitCode_q;
    end

endmodule

// File: tb/tb_commit_trace_sched.sv
// Randomized and directed bench for commit_trace_sched against a queue-based reference model.
module tb_commit_trace_sched;

    localparam int DEPTH     = 4;
    localparam int HALT_WAIT = 2;
    localparam int CW        = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmtValid, cmtReady, cmtEbreak;
    logic [63:0]   cmtPc, cmtA0;
    logic [31:0]   cmtInst;
    logic          trValid, trReady;
    logic [63:0]   trPc;
    logic [31:0]   trInst, trFlag;
    logic [CW-1:0] count;
    logic          halt;
    logic [63:0]   exitCode;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        bit          eb;
    } rec_t;

    rec_t        modelQ[$];
    bit          stopped;
    bit          ebDone;
    longint      edgeCnt;
    longint      ebEmitEdge;
    logic [63:0] expExit;

    always #5 clk = ~clk;

    commit_trace_sched #(.DEPTH(DEPTH), .HALT_WAIT(HALT_WAIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmt_valid_i(cmtValid), .cmt_ready_o(cmtReady),
        .cmt_pc_i(cmtPc), .cmt_inst_i(cmtInst),
        .cmt_ebreak_i(cmtEbreak), .cmt_a0_i(cmtA0),
        .tr_valid_o(trValid), .tr_ready_i(trReady),
        .tr_pc_o(trPc), .tr_inst_o(trInst), .tr_flag_o(trFlag),
        .count_o(count), .halt_o(halt), .exit_code_o(exitCode)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        modelQ.delete();
        stopped    = 1'b0;
        ebDone     = 1'b0;
        ebEmitEdge = 0;
        expExit    = '0;
    endfunction

    // One cycle: drive inputs, compare against the model, clock, then advance the model.
    task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                                 input logic eb, input logic [63:0] a0, input logic trr,
                                 input logic r, output bit accepted);
        bit expReady, expValid, expHalt, emt;
        rec_t rec;
        cmtValid  = v;
        cmtPc     = pc;
        cmtInst   = inst;
        cmtEbreak = eb;
        cmtA0     = a0;
        trReady   = trr;
        rst       = r;
        #1;
        expValid = (modelQ.size() != 0);
        expReady = !stopped && (modelQ.size() < DEPTH);
        expHalt  = ebDone && (edgeCnt >= ebEmitEdge + 1 + HALT_WAIT);
        checkOutput("count", 64'(count), 64'(modelQ.size()));
        checkOutput("tr_valid", 64'(trValid), 64'(expValid));
        checkOutput("cmt_ready", 64'(cmtReady), 64'(expReady));
        checkOutput("halt", 64'(halt), 64'(expHalt));
        checkOutput("exit_code", exitCode, expExit);
        if (expValid) begin
            checkOutput("tr_pc", trPc, modelQ[0].pc);
            checkOutput("tr_inst", 64'(trInst), 64'(modelQ[0].inst));
            checkOutput("tr_flag", 64'(trFlag), modelQ[0].eb ? 64'd1 : 64'd0);
        end
        accepted = v && expReady && !r;
        emt      = expValid && trr && !r;
        @(posedge clk);
        edgeCnt++;
        if (r) begin
            modelReset();
        end else begin
            if (emt) begin
                rec = modelQ.pop_front();
                if (rec.eb) begin
                    ebDone     = 1'b1;
                    ebEmitEdge = edgeCnt;
                end
            end
            if (accepted) begin
                rec.pc   = pc;
                rec.inst = inst;
                rec.eb   = eb;
                modelQ.push_back(rec);
                if (eb) begin
                    stopped = 1'b1;
                    expExit = a0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic trr);
        bit acc;
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 64'h0, trr, 1'b0, acc);
    endtask

    task automatic pushRecord(input logic [63:0] pc, input logic eb, input logic [63:0] a0, input logic trr);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++)
            applyStimulus(1'b1, pc, pc[31:0] ^ 32'h0000_0013, eb, a0, trr, 1'b0, acc);
        if (!acc) checkOutput("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic doReset();
        bit acc;
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        bit acc;
        cmtValid = 0; cmtPc = 0; cmtInst = 0; cmtEbreak = 0; cmtA0 = 0; trReady = 0;
        rst = 1'b1;
        edgeCnt = 0;
        repeat (2) @(posedge clk);
        modelReset();
        @(negedge clk);

        // Directed: post-reset state, streaming pass-through.
        idle(1, 1'b0);
        for (int i = 0; i < 3; i++) pushRecord(64'h8000_0000 + 64'(4 * i), 1'b0, 64'h0, 1'b1);
        idle(2, 1'b1);

        // Directed: fill, refuse a fifth record while full, then drain.
        for (int i = 0; i < 4; i++) pushRecord(64'h8000_0100 + 64'(4 * i), 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 64'h8000_0110, 32'h1234, 1'b0, 64'h0, 1'b0, 1'b0, acc);
        pushRecord(64'h8000_0110, 1'b0, 64'h0, 1'b1);
        idle(6, 1'b1);

        // Directed: ebreak with exit code 0, trailing records refused.
        pushRecord(64'h8000_000c, 1'b1, 64'h0, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 64'h9000_0000 + 64'(i), 32'h55, 1'b0, 64'h77, 1'b1, 1'b0, acc);

        // Directed: buffered ebreak behind three records, exit code 1.
        doReset();
        for (int i = 0; i < 3; i++) pushRecord(64'h8000_0200 + 64'(4 * i), 1'b0, 64'h0, 1'b0);
        pushRecord(64'h8000_020c, 1'b1, 64'h1, 1'b0);
        idle(10, 1'b0);
        idle(10, 1'b1);

        // Directed: reset while draining with two records buffered.
        doReset();
        pushRecord(64'h8000_0300, 1'b0, 64'h0, 1'b0);
        pushRecord(64'h8000_0304, 1'b1, 64'h5, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 1'b0, 1'b1, acc);
        idle(2, 1'b0);

        // Random episodes, with occasional ebreaks and mid-run resets.
        for (int ep = 0; ep < 6; ep++) begin
            doReset();
            for (int c = 0; c < 150; c++) begin
                applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom,
                              $urandom_range(0, 15) == 0, {$urandom, $urandom},
                              $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, acc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
